writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Write-side front end of the 16x32 register file.
- Merges results from the single-cycle ALU and the multi-cycle load path into the file's single write port (write_enable/write_addr/write_data).
- Redirects R15 (PC) results to a separate PC-update output, because the file ignores R15 writes.
- Keeps a busy scoreboard of registers with outstanding loads, so decode can stall on RAW hazards.

Parameters:
- FIFO_DEPTH, 2, load-result buffer entries (power of two, >=2)
- PC_REG, 4'd15, register index redirected to the PC output

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- alu_valid  input  1  ALU result present this cycle (always accepted, no ready)
- alu_addr  input  4  ALU destination register
- alu_data  input  32  ALU result
- mem_valid  input  1  load result offered
- mem_ready  output  1  buffer can accept load result
- mem_addr  input  4  load destination register
- mem_data  input  32  load data
- issue_valid  input  1  a load is issued this cycle
- issue_addr  input  4  destination of the issued load
- rs1_addr  input  4  decode source operand 1
- rs2_addr  input  4  decode source operand 2
- stall  output  1  a decode source is busy
- busy  output  16  per-register outstanding-load flags
- write_enable  output  1  register file write strobe
- write_addr  output  4  register file write address
- write_data  output  32  register file write data
- pc_write_valid  output  1  PC redirect strobe
- pc_write_data  output  32  PC redirect target
- waw_err  output  1  sticky: ALU wrote a busy register

Behaviour:
- Reset, asynchronous: every output register is 0, busy=0, FIFO empty with count=0 and pointers=0, waw_err=0.
- After reset, mem_ready=1 combinationally.
- FIFO push:
  - mem_ready = (count < FIFO_DEPTH), computed from count only.
  - A full FIFO does not accept a push in the same cycle it pops.
  - Push when mem_valid && mem_ready.
- Arbitration, each cycle:
  - If alu_valid, the ALU result is selected.
  - Else if count>0, the FIFO head is popped and selected.
  - Else nothing is selected.
  - ALU has absolute priority. The load path is throttled only via mem_ready.
- Output stage (registered):
  - At the edge, a selected result with addr != PC_REG sets write_enable=1 and loads write_addr/write_data.
  - A selected result with addr == PC_REG sets pc_write_valid=1 and pc_write_data=data, with write_enable=0.
  - With no selection, both strobes are 0 and addr/data hold their values.
  - Latency: ALU input in cycle N gives the strobe in cycle N+1, and the register file captures at the end of N+1.
  - Latency: a load pushed at edge E is popped at the earliest at edge E+1, so the strobe is high in the cycle after E+1.
- Push and pop in the same cycle: count is unchanged and the pointers advance independently. Pointers wrap modulo FIFO_DEPTH.
- Scoreboard:
  - issue_valid sets busy[issue_addr] at the edge.
  - A FIFO pop with addr A clears busy[A] at the same edge.
  - Set and clear of the same index in the same cycle: set wins.
  - Issue to PC_REG is legal; its bit clears when its pc_write fires.
- stall = busy[rs1_addr] | busy[rs2_addr], combinational. It does not include a clear happening this cycle; there is no bypass.
- waw_err: set when alu_valid && busy[alu_addr]; cleared only by reset. The write itself still proceeds.
- Ordering: loads retire in arrival order. ALU and load results are not reordered relative to busy; decode must stall on busy destinations.
- Reset mid-operation: buffered loads are discarded and the scoreboard is cleared. Any strobe in flight is dropped at assertion.

Decomposition:
- Shared package, constants only: REG_ADDR_W=4, DATA_W=32, NUM_REGS=16, PC_REG=15, SP_RESET=32'h00001000 (kept alongside for the file).
- One natural sub-module: wb_fifo, a parameterised sync FIFO with push/pop/count/full/empty and asynchronous active-high reset.
- Arbiter, output stage and scoreboard stay in the top module.

Test Plan:
- Reset then idle: rst pulse -> all strobes 0, busy=16'h0, mem_ready=1, stall=0, waw_err=0.
- Single ALU write: alu_valid, addr=3, data=32'hDEADBEEF in cycle N -> cycle N+1 write_enable=1, write_addr=3, write_data=32'hDEADBEEF; cycle N+2 write_enable=0.
- Load with scoreboard:
  - issue_valid, addr=5 -> busy[5]=1.
  - rs1_addr=5 -> stall=1.
  - mem push addr=5, data=32'h12345678 with ALU idle -> write strobe one cycle after the pop, busy[5]=0, stall=0.
- ALU starvation of loads:
  - alu_valid held for 4 cycles while mem_valid offers 3 loads -> 2 accepted, then mem_ready=0.
  - No load writes while ALU active.
  - After ALU drops, loads write in order on consecutive cycles, and mem_ready returns to 1 once a pop occurs.
- PC redirect: load to addr 15 with data 32'h00000400 -> pc_write_valid=1, pc_write_data=32'h00000400, write_enable=0, busy[15] cleared.
- Hazards and reset:
  - ALU write to a busy register 7 -> write occurs and waw_err=1 sticky.
  - Same-cycle issue_addr=7 and pop addr=7 -> busy[7] stays 1.
  - rst with 2 entries buffered -> FIFO empty, busy=0, no later writes.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// Shared constants for the register-file write-side front end.
package writeback_arbiter_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 16;

    localparam logic [REG_ADDR_W-1:0] PC_REG   = 4'd15;
    localparam logic [DATA_W-1:0]     SP_RESET = 32'h00001000;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering load results until the write port is free.
module wb_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = REG_ADDR_W + DATA_W,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load results onto the register-file write port, redirects
// PC writes, and tracks registers with outstanding loads for decode stalls.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int                     FIFO_DEPTH = 2,
    parameter logic [REG_ADDR_W-1:0]  PC_REG     = 4'd15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_addr,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  stall,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  write_enable,
    output logic [REG_ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0]     write_data,
    output logic                  pc_write_valid,
    output logic [DATA_W-1:0]     pc_write_data,
    output logic                  waw_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = REG_ADDR_W + DATA_W;

    logic [CW-1:0]         fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [EW-1:0]         fifo_dout;
    logic                  push;
    logic                  pop;
    logic [REG_ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0]     head_data;

    logic                  sel_valid;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_data;

    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  pcv_q, pcv_d;
    logic [DATA_W-1:0]     pcd_q, pcd_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  waw_q, waw_d;

    assign mem_ready = (fifo_count < CW'(FIFO_DEPTH));
    assign push      = mem_valid && !fifo_full;
    // ALU has absolute priority; loads only drain on ALU-idle cycles.
    assign pop       = !alu_valid && !fifo_empty;
    assign head_addr = fifo_dout[EW-1 -: REG_ADDR_W];
    assign head_data = fifo_dout[DATA_W-1:0];

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({mem_addr, mem_data}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_addr  = alu_addr;
            sel_data  = alu_data;
        end else if (pop) begin
            sel_valid = 1'b1;
            sel_addr  = head_addr;
            sel_data  = head_data;
        end
    end

    always_comb begin
        we_d    = 1'b0;
        pcv_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        pcd_d   = pcd_q;
        if (sel_valid) begin
            if (sel_addr == PC_REG) begin
                pcv_d = 1'b1;
                pcd_d = sel_data;
            end else begin
                we_d    = 1'b1;
                waddr_d = sel_addr;
                wdata_d = sel_data;
            end
        end
    end

    // Clear first so a same-cycle issue to the retiring register wins.
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head_addr] = 1'b0;
        end
        if (issue_valid) begin
            busy_d[issue_addr] = 1'b1;
        end
    end

    assign waw_d = waw_q | (alu_valid & busy_q[alu_addr]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            pcv_q   <= 1'b0;
            pcd_q   <= '0;
            busy_q  <= '0;
            waw_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            pcv_q   <= pcv_d;
            pcd_q   <= pcd_d;
            busy_q  <= busy_d;
            waw_q   <= waw_d;
        end
    end

    assign stall          = busy_q[rs1_addr] | busy_q[rs2_addr];
    assign busy           = busy_q;
    assign write_enable   = we_q;
    assign write_addr     = waddr_q;
    assign write_data     = wdata_q;
    assign pc_write_valid = pcv_q;
    assign pc_write_data  = pcd_q;
    assign waw_err        = waw_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: a cycle model predicts each strobe.
module tb_writeback_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0;
    logic [3:0]  alu_addr = '0;
    logic [31:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [3:0]  mem_addr = '0;
    logic [31:0] mem_data = '0;
    logic        issue_valid = 1'b0;
    logic [3:0]  issue_addr = '0;
    logic [3:0]  rs1_addr = '0;
    logic [3:0]  rs2_addr = '0;
    logic        stall;
    logic [15:0] busy;
    logic        write_enable;
    logic [3:0]  write_addr;
    logic [31:0] write_data;
    logic        pc_write_valid;
    logic [31:0] pc_write_data;
    logic        waw_err;

    writeback_arbiter #(.FIFO_DEPTH(DEPTH), .PC_REG(4'd15)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_addr       (alu_addr),
        .alu_data       (alu_data),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .issue_valid    (issue_valid),
        .issue_addr     (issue_addr),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .stall          (stall),
        .busy           (busy),
        .write_enable   (write_enable),
        .write_addr     (write_addr),
        .write_data     (write_data),
        .pc_write_valid (pc_write_valid),
        .pc_write_data  (pc_write_data),
        .waw_err        (waw_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_pc;
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         expq[$];
    wr_t         mfifo[$];
    logic [15:0] busy_m = '0;
    bit          waw_m = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: predict from the pre-edge inputs, then compare after the edge.
    task automatic cyc(output bit acc);
        wr_t         e;
        bit          sel;
        logic [15:0] nb;
        int          pre_cnt;
        acc = 1'b0;
        sel = 1'b0;
        #1;
        pre_cnt = mfifo.size();
        check("mem_ready", 32'(mem_ready), 32'(pre_cnt < DEPTH));
        check("stall", 32'(stall), 32'(busy_m[rs1_addr] | busy_m[rs2_addr]));
        nb = busy_m;
        if (alu_valid) begin
            e.is_pc = (alu_addr == 4'd15);
            e.addr  = alu_addr;
            e.data  = alu_data;
            sel     = 1'b1;
            if (busy_m[alu_addr]) waw_m = 1'b1;
        end else if (pre_cnt > 0) begin
            e = mfifo.pop_front();
            sel = 1'b1;
            nb[e.addr] = 1'b0;
        end
        if (mem_valid && pre_cnt < DEPTH) begin
            wr_t l;
            l.is_pc = (mem_addr == 4'd15);
            l.addr  = mem_addr;
            l.data  = mem_data;
            mfifo.push_back(l);
            acc = 1'b1;
        end
        if (issue_valid) nb[issue_addr] = 1'b1;
        busy_m = nb;
        if (sel) expq.push_back(e);
        @(posedge clk);
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("write_enable", 32'(write_enable), 32'(!e.is_pc));
            check("pc_write_valid", 32'(pc_write_valid), 32'(e.is_pc));
            if (e.is_pc) begin
                check("pc_write_data", pc_write_data, e.data);
            end else begin
                check("write_addr", 32'(write_addr), 32'(e.addr));
                check("write_data", write_data, e.data);
            end
        end else begin
            check("idle_we", 32'(write_enable), 32'd0);
            check("idle_pcv", 32'(pc_write_valid), 32'd0);
        end
        check("busy", 32'(busy), 32'(busy_m));
        check("waw_err", 32'(waw_err), 32'(waw_m));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("rst_we", 32'(write_enable), 32'd0);
        check("rst_pcv", 32'(pc_write_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_waw", 32'(waw_err), 32'd0);
        check("rst_ready", 32'(mem_ready), 32'd1);
        check("rst_stall", 32'(stall), 32'd0);
        mfifo.delete();
        expq.delete();
        busy_m = '0;
        waw_m  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit acc;
        int li;
        wr_t loads[3];
        loads[0] = '{1'b0, 4'd8,  32'h1111_0008};
        loads[1] = '{1'b0, 4'd9,  32'h2222_0009};
        loads[2] = '{1'b0, 4'd10, 32'h3333_000A};

        do_reset();
        cyc(acc);
        cyc(acc);

        // single ALU write
        alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'hDEADBEEF;
        cyc(acc);
        check("alu_addr3", 32'(write_addr), 32'd3);
        alu_valid = 1'b0;
        cyc(acc);

        // load with scoreboard
        issue_valid = 1'b1; issue_addr = 4'd5;
        cyc(acc);
        issue_valid = 1'b0; rs1_addr = 4'd5;
        #1 check("stall_busy5", 32'(stall), 32'd1);
        mem_valid = 1'b1; mem_addr = 4'd5; mem_data = 32'h12345678;
        cyc(acc);
        mem_valid = 1'b0;
        cyc(acc);
        check("load5_data", write_data, 32'h12345678);
        #1 check("stall_clr5", 32'(stall), 32'd0);
        cyc(acc);

        // ALU starves loads
        li = 0;
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_addr = 4'(i + 1); alu_data = 32'hA000_0000 + 32'(i);
            mem_valid = (li < 3);
            if (li < 3) begin mem_addr = loads[li].addr; mem_data = loads[li].data; end
            cyc(acc);
            if (acc) li++;
        end
        check("starve_accepted", 32'(li), 32'd2);
        alu_valid = 1'b0;
        #1 check("starve_ready0", 32'(mem_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            mem_valid = (li < 3);
            if (li < 3) begin mem_addr = loads[li].addr; mem_data = loads[li].data; end
            cyc(acc);
            if (acc) li++;
        end
        mem_valid = 1'b0;
        check("starve_all_loaded", 32'(li), 32'd3);

        // PC redirect
        issue_valid = 1'b1; issue_addr = 4'd15;
        cyc(acc);
        issue_valid = 1'b0;
        mem_valid = 1'b1; mem_addr = 4'd15; mem_data = 32'h00000400;
        cyc(acc);
        mem_valid = 1'b0;
        cyc(acc);
        check("pc_data", pc_write_data, 32'h00000400);
        check("pc_no_we", 32'(write_enable), 32'd0);
        check("pc_busy15", 32'(busy[15]), 32'd0);

        // WAW on busy register 7
        issue_valid = 1'b1; issue_addr = 4'd7;
        cyc(acc);
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 32'h0000_0077;
        cyc(acc);
        alu_valid = 1'b0;
        check("waw_set", 32'(waw_err), 32'd1);
        cyc(acc);

        // same-cycle issue and pop of register 7
        mem_valid = 1'b1; mem_addr = 4'd7; mem_data = 32'h0000_0088;
        cyc(acc);
        mem_valid = 1'b0;
        issue_valid = 1'b1; issue_addr = 4'd7;
        cyc(acc);
        issue_valid = 1'b0;
        check("set_wins7", 32'(busy[7]), 32'd1);
        cyc(acc);

        // reset with two loads buffered behind the ALU
        alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 32'h0000_0101;
        mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 32'hBBBB_0002;
        cyc(acc);
        mem_addr = 4'd3; mem_data = 32'hBBBB_0003;
        cyc(acc);
        mem_valid = 1'b0;
        do_reset();
        alu_valid = 1'b0;
        for (int i = 0; i < 3; i++) cyc(acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
